// File: rtl/vga_pattern_gen.sv
// Pixel-colour stage behind a 640x480 VGA timing generator: four test patterns
// (bars, checker, gradient, bouncing box) with RGB and sync/de on a matched 2-flop pipeline.
`timescale 1ns/1ps
module vga_pattern_gen #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int RGB_W       = 4,
   parameter int BOX_SIZE    = 32,
   parameter int BOX_STEP    = 2,
   parameter int CHECK_SHIFT = 5
) (
   input  logic             clk_pix,
   input  logic             resetn,
   input  logic [9:0]       hcount,
   input  logic [9:0]       vcount,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             de_in,
   input  logic [1:0]       pattern_sel,
   input  logic             freeze,
   output logic [RGB_W-1:0] vga_r,
   output logic [RGB_W-1:0] vga_g,
   output logic [RGB_W-1:0] vga_b,
   output logic             vga_hsync,
   output logic             vga_vsync,
   output logic             vga_de,
   output logic [7:0]       frame_count
);

   localparam int               BAR_W   = H_ACTIVE / 8;
   localparam logic [10:0]      X_MAX   = 11'(H_ACTIVE - BOX_SIZE);
   localparam logic [10:0]      Y_MAX   = 11'(V_ACTIVE - BOX_SIZE);
   localparam logic [10:0]      STEP    = 11'(BOX_STEP);
   localparam logic [10:0]      SIZE    = 11'(BOX_SIZE);
   localparam logic [RGB_W-1:0] FULL    = {RGB_W{1'b1}};
   localparam logic [RGB_W-1:0] BG_BLUE = RGB_W'((1 << (RGB_W - 1)) - 1);

   typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_t;

   // One frame of bounce motion for one axis; returns {next_dir, next_pos}.
   function automatic logic [10:0] axis_next(input logic [9:0] pos, input dir_t dir,
                                             input logic [10:0] lim);
      logic [10:0] pos11;
      logic [9:0]  npos;
      dir_t        ndir;
      pos11 = {1'b0, pos};
      npos  = pos;
      ndir  = dir;
      case (dir)
         DIR_INC: begin
            if (pos11 + STEP >= lim) begin
               npos = lim[9:0];
               ndir = DIR_DEC;
            end else begin
               npos = 10'(pos11 + STEP);
               ndir = DIR_INC;
            end
         end
         DIR_DEC: begin
            if (pos11 <= STEP) begin
               npos = 10'd0;
               ndir = DIR_INC;
            end else begin
               npos = 10'(pos11 - STEP);
               ndir = DIR_DEC;
            end
         end
         default: begin
            npos = pos;
            ndir = dir;
         end
      endcase
      return {ndir, npos};
   endfunction

   logic [1:0]       pattern_q_r;
   logic [9:0]       box_x_r, box_y_r, box_x_next_s, box_y_next_s;
   dir_t             dir_x_r, dir_y_r, dir_x_next_s, dir_y_next_s;
   logic [10:0]      nx_s, ny_s;
   logic             frame_tick_s;
   logic             in_box_s;
   logic             checker_s;
   logic [2:0]       bar_idx_s;
   logic [RGB_W-1:0] pix_r_s, pix_g_s, pix_b_s;
   logic [RGB_W-1:0] s1_r_r, s1_g_r, s1_b_r;
   logic             s1_de_r, s1_hs_r, s1_vs_r;

   assign frame_tick_s = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));
   assign checker_s    = hcount[CHECK_SHIFT] ^ vcount[CHECK_SHIFT];
   assign in_box_s     = ({1'b0, hcount} >= {1'b0, box_x_r}) &&
                         ({1'b0, hcount} <  {1'b0, box_x_r} + SIZE) &&
                         ({1'b0, vcount} >= {1'b0, box_y_r}) &&
                         ({1'b0, vcount} <  {1'b0, box_y_r} + SIZE);

   // Box motion next-state: both axes advance only on an unfrozen frame tick.
   always_comb begin
      nx_s         = axis_next(box_x_r, dir_x_r, X_MAX);
      ny_s         = axis_next(box_y_r, dir_y_r, Y_MAX);
      box_x_next_s = box_x_r;
      box_y_next_s = box_y_r;
      dir_x_next_s = dir_x_r;
      dir_y_next_s = dir_y_r;
      if (frame_tick_s && !freeze) begin
         box_x_next_s = nx_s[9:0];
         box_y_next_s = ny_s[9:0];
         dir_x_next_s = dir_t'(nx_s[10]);
         dir_y_next_s = dir_t'(ny_s[10]);
      end else begin
         box_x_next_s = box_x_r;
         box_y_next_s = box_y_r;
      end
   end

   // Frame-rate state: pattern latch, frame counter and box position/direction.
   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) begin
         pattern_q_r <= 2'd0;
         frame_count <= 8'd0;
         box_x_r     <= 10'd0;
         box_y_r     <= 10'd0;
         dir_x_r     <= DIR_INC;
         dir_y_r     <= DIR_INC;
      end else begin
         box_x_r <= box_x_next_s;
         box_y_r <= box_y_next_s;
         dir_x_r <= dir_x_next_s;
         dir_y_r <= dir_y_next_s;
         if (frame_tick_s) begin
            pattern_q_r <= pattern_sel;
            frame_count <= frame_count + 8'd1;
         end
      end
   end

   // Pixel colour decode; bar index counts how many bar boundaries h has passed.
   always_comb begin
      bar_idx_s = 3'd0;
      for (int i = 1; i < 8; i++) begin
         bar_idx_s = bar_idx_s + 3'({1'b0, hcount} >= 11'(i * BAR_W));
      end
      pix_r_s = {RGB_W{1'b0}};
      pix_g_s = {RGB_W{1'b0}};
      pix_b_s = {RGB_W{1'b0}};
      case (pattern_q_r)
         2'd0: begin
            // white,yellow,cyan,green,magenta,red,blue,black maps to inverted index bits
            pix_r_s = {RGB_W{~bar_idx_s[1]}};
            pix_g_s = {RGB_W{~bar_idx_s[2]}};
            pix_b_s = {RGB_W{~bar_idx_s[0]}};
         end
         2'd1: begin
            pix_r_s = {RGB_W{checker_s}};
            pix_g_s = {RGB_W{checker_s}};
            pix_b_s = {RGB_W{checker_s}};
         end
         2'd2: begin
            pix_r_s = hcount[9 -: RGB_W];
            pix_g_s = vcount[8 -: RGB_W];
            pix_b_s = {RGB_W{1'b0}};
         end
         2'd3: begin
            if (in_box_s) begin
               pix_r_s = FULL;
               pix_g_s = FULL;
               pix_b_s = FULL;
            end else begin
               pix_r_s = {RGB_W{1'b0}};
               pix_g_s = {RGB_W{1'b0}};
               pix_b_s = BG_BLUE;
            end
         end
         default: begin
            pix_r_s = {RGB_W{1'b0}};
            pix_g_s = {RGB_W{1'b0}};
            pix_b_s = {RGB_W{1'b0}};
         end
      endcase
   end

   // Stage 1: capture decoded colour with its sync/de.
   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) begin
         s1_r_r  <= {RGB_W{1'b0}};
         s1_g_r  <= {RGB_W{1'b0}};
         s1_b_r  <= {RGB_W{1'b0}};
         s1_de_r <= 1'b0;
         s1_hs_r <= 1'b1;
         s1_vs_r <= 1'b1;
      end else begin
         s1_r_r  <= pix_r_s;
         s1_g_r  <= pix_g_s;
         s1_b_r  <= pix_b_s;
         s1_de_r <= de_in;
         s1_hs_r <= hsync_in;
         s1_vs_r <= vsync_in;
      end
   end

   // Stage 2: output registers, colour forced black outside active video.
   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) begin
         vga_r     <= {RGB_W{1'b0}};
         vga_g     <= {RGB_W{1'b0}};
         vga_b     <= {RGB_W{1'b0}};
         vga_de    <= 1'b0;
         vga_hsync <= 1'b1;
         vga_vsync <= 1'b1;
      end else begin
         vga_r     <= s1_de_r ? s1_r_r : {RGB_W{1'b0}};
         vga_g     <= s1_de_r ? s1_g_r : {RGB_W{1'b0}};
         vga_b     <= s1_de_r ? s1_b_r : {RGB_W{1'b0}};
         vga_de    <= s1_de_r;
         vga_hsync <= s1_hs_r;
         vga_vsync <= s1_vs_r;
      end
   end

endmodule
